// File: rtl/route_arbiter_pkg.sv
// Shared router definitions: arbiter state encoding, mux select encoding, data width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package route_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no token outstanding
        ISSUE = 2'd1,   // token offered to the mux
        BUSY  = 2'd2    // token accepted, waiting for the mux to finish the send
    } state_t;

    // Select encoding on the mux select channel; the mux decodes the same values
    localparam logic SEL_X = 1'b0;
    localparam logic SEL_Y = 1'b1;

    // Router data path width
    localparam int DATA_W = 11;

    // Burst counter width and saturation point
    localparam int         RUN_W   = 4;
    localparam logic [3:0] RUN_MAX = 4'hF;

    // Saturating increment for the burst counter
    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
        return (v == RUN_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/route_arbiter_if.sv
// Request / select-token / completion bundle between the input ports, the arbiter and the output mux.
// Latency: n/a (wires only).
// Backpressure: sel_valid/sel_ready handshake on the select token.
interface route_arbiter_if;
    import route_arbiter_pkg::*;

    logic x_req;
    logic y_req;
    logic sel_valid;
    logic sel_data;
    logic sel_ready;
    logic done;
    logic busy;
    logic err;

    // Arbiter side
    modport master (
        input  x_req, y_req, sel_ready, done,
        output sel_valid, sel_data, busy, err
    );

    // Port / mux side
    modport slave (
        output x_req, y_req, sel_ready, done,
        input  sel_valid, sel_data, busy, err
    );

endinterface

// File: rtl/route_arbiter_rr_pick.sv
// Round-robin port choice with a burst allowance for the port granted last.
// Latency: combinational.
// Backpressure: none; the caller decides when the choice is consumed.
module rr_pick
    import route_arbiter_pkg::*;
#(
    parameter int BURST = 1
) (
    input  logic             x_req,
    input  logic             y_req,
    input  logic             last,
    input  logic [RUN_W-1:0] run,
    output logic             grant_valid,
    output logic             grant_port
);

    localparam logic [RUN_W-1:0] BURST_L = RUN_W'(BURST);

    // Choose a port: a lone requester always wins; under contention `last` keeps
    // the link while its burst has started and not yet reached BURST. A zero run
    // means `last` has no burst in progress (only true out of reset), so the
    // pointer hands the first contention to the other port, i.e. X.
    always_comb begin
        grant_valid = x_req | y_req;
        grant_port  = SEL_X;
        if (x_req && y_req) begin
            if ((run != '0) && (run < BURST_L)) begin
                grant_port = last;
            end else begin
                grant_port = ~last;
            end
        end else if (y_req) begin
            grant_port = SEL_Y;
        end
    end

endmodule

// File: rtl/route_arbiter.sv
// Arbitrates ports X/Y onto one output link by issuing one select token per packet to the 2:1 mux.
// Latency: request to sel_valid 1 cycle; minimum token spacing 3 cycles; all outputs registered.
// Backpressure: token held stable until sel_ready; next token held off until done or watchdog expiry.
module route_arbiter
    import route_arbiter_pkg::*;
#(
    parameter int BURST   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    route_arbiter_if.master bus
);

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

    state_t           state, state_nxt;
    logic             last, last_nxt;
    logic [RUN_W-1:0] run, run_nxt;
    logic [15:0]      wd, wd_nxt;
    logic [15:0]      wd_inc;
    logic             sel_valid_q, sel_valid_nxt;
    logic             sel_data_q, sel_data_nxt;
    logic             err_q, err_nxt;
    logic             grant_valid;
    logic             grant_port;

    rr_pick #(
        .BURST (BURST)
    ) u_pick (
        .x_req       (bus.x_req),
        .y_req       (bus.y_req),
        .last        (last),
        .run         (run),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    assign wd_inc = wd + 16'd1;

    // State and output registers; reset leaves X ahead in the first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last        <= SEL_Y;
            run         <= '0;
            wd          <= '0;
            sel_valid_q <= 1'b0;
            sel_data_q  <= SEL_X;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            run         <= run_nxt;
            wd          <= wd_nxt;
            sel_valid_q <= sel_valid_nxt;
            sel_data_q  <= sel_data_nxt;
            err_q       <= err_nxt;
        end
    end

    // Next-state logic: grant in IDLE, hold token in ISSUE, await done or watchdog in BUSY
    always_comb begin
        state_nxt     = state;
        last_nxt      = last;
        run_nxt       = run;
        wd_nxt        = wd;
        sel_valid_nxt = sel_valid_q;
        sel_data_nxt  = sel_data_q;
        err_nxt       = err_q;
        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt     = ISSUE;
                    sel_valid_nxt = 1'b1;
                    sel_data_nxt  = grant_port;
                    run_nxt       = (grant_port == last) ? run_inc(run) : 4'd1;
                    last_nxt      = grant_port;
                end
            end
            ISSUE: begin
                // requests are not looked at here; a dropped request keeps its token
                if (bus.sel_ready) begin
                    state_nxt     = BUSY;
                    sel_valid_nxt = 1'b0;
                    wd_nxt        = '0;
                end
            end
            BUSY: begin
                wd_nxt = wd_inc;
                if (bus.done) begin
                    // completion wins over a watchdog expiry in the same cycle
                    state_nxt = IDLE;
                end else if (wd_inc == WD_LIMIT) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                sel_valid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.sel_valid = sel_valid_q;
    assign bus.sel_data  = sel_data_q;
    assign bus.busy      = (state != IDLE);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_route_arbiter.sv
// Self-checking bench: rr_pick vector table plus directed sequences on two arbiters (BURST=1 and BURST=3).
// Latency: n/a.
// Backpressure: sel_ready driven directly; done pulsed one cycle into BUSY when auto_done is set.
module tb_route_arbiter;
    import route_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x_req = 1'b0;
    logic y_req = 1'b0;
    logic sel_ready = 1'b0;
    logic done = 1'b0;
    logic auto_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // free-running cycle stamp for token spacing
    always @(posedge clk) cyc <= cyc + 1;

    route_arbiter_if ifa();
    route_arbiter_if ifb();

    assign ifa.x_req     = x_req;
    assign ifa.y_req     = y_req;
    assign ifa.sel_ready = sel_ready;
    assign ifa.done      = done;
    assign ifb.x_req     = x_req;
    assign ifb.y_req     = y_req;
    assign ifb.sel_ready = sel_ready;
    assign ifb.done      = done;

    route_arbiter #(.BURST(1), .TIMEOUT(4)) dut1 (.clk(clk), .rst(rst), .bus(ifa));
    route_arbiter #(.BURST(3), .TIMEOUT(4)) dut3 (.clk(clk), .rst(rst), .bus(ifb));

    // standalone picker with BURST=3
    logic       p_x, p_y, p_last, p_gv, p_gp;
    logic [3:0] p_run;
    rr_pick #(.BURST(3)) u_pick (
        .x_req(p_x), .y_req(p_y), .last(p_last), .run(p_run),
        .grant_valid(p_gv), .grant_port(p_gp)
    );

    typedef struct {
        logic       x;
        logic       y;
        logic       last;
        logic [3:0] run;
        logic       gv;
        logic       gp;
    } pick_vec_t;

    pick_vec_t vecs[13];
    int exp3[8] = '{0, 0, 0, 1, 1, 1, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // advance one edge, sample 1ns later, and model the mux completing one cycle into BUSY
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_done && ifa.busy && !ifa.sel_valid) done = 1'b1;
        else done = 1'b0;
    endtask

    task automatic wait_token(input string name, output int t);
        bit seen;
        seen = 0;
        t = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (ifa.sel_valid) begin
                seen = 1;
                t = cyc;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: no token within 20 cycles", name);
        end
    endtask

    task automatic check_both(input string name, input logic a, input logic b, input logic exp);
        check({name, "_b1"}, a, exp);
        check({name, "_b3"}, b, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, tprev;

        // rr_pick table: {x, y, last, run, grant_valid, grant_port}
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'd5,  1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd9,  1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'd0,  1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'd1,  1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'd2,  1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd3,  1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd3,  1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'd15, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 4'd15, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0};

        // reset state
        tick();
        tick();
        check_both("rst_sel_valid", ifa.sel_valid, ifb.sel_valid, 1'b0);
        check_both("rst_sel_data",  ifa.sel_data,  ifb.sel_data,  1'b0);
        check_both("rst_busy",      ifa.busy,      ifb.busy,      1'b0);
        check_both("rst_err",       ifa.err,       ifb.err,       1'b0);
        rst = 1'b0;

        // picker vectors
        for (int i = 0; i < 13; i++) begin
            p_x = vecs[i].x;
            p_y = vecs[i].y;
            p_last = vecs[i].last;
            p_run = vecs[i].run;
            #1;
            check($sformatf("pick_valid[%0d]", i), p_gv, vecs[i].gv);
            check($sformatf("pick_port[%0d]", i),  p_gp, vecs[i].gp);
        end

        // single requester Y, back-to-back tokens
        sel_ready = 1'b1;
        auto_done = 1'b1;
        y_req = 1'b1;
        tprev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_token("single", t);
            check_both($sformatf("single_data[%0d]", i), ifa.sel_data, ifb.sel_data, 1'b1);
            if (i > 0) check($sformatf("single_spacing[%0d]", i), t - tprev, 3);
            tprev = t;
        end
        y_req = 1'b0;
        repeat (5) tick();
        check_both("single_drain_busy", ifa.busy, ifb.busy, 1'b0);

        // contention: BURST=1 alternates, BURST=3 runs in threes
        x_req = 1'b1;
        y_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_token("contend", t);
            check($sformatf("contend_b1[%0d]", i), ifa.sel_data, i % 2);
            check($sformatf("contend_b3[%0d]", i), ifb.sel_data, exp3[i]);
        end
        x_req = 1'b0;
        y_req = 1'b0;
        repeat (5) tick();
        check_both("contend_drain_busy", ifa.busy, ifb.busy, 1'b0);

        // backpressure: token held 5 cycles with X request dropped, taken on the 6th
        sel_ready = 1'b0;
        x_req = 1'b1;
        wait_token("bp", t);
        x_req = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            check_both($sformatf("bp_valid[%0d]", i), ifa.sel_valid, ifb.sel_valid, 1'b1);
            check_both($sformatf("bp_data[%0d]", i),  ifa.sel_data,  ifb.sel_data,  1'b0);
            if (i < 6) tick();
        end
        sel_ready = 1'b1;
        tick();
        check_both("bp_accept_valid", ifa.sel_valid, ifb.sel_valid, 1'b0);
        check_both("bp_accept_busy",  ifa.busy,      ifb.busy,      1'b1);
        repeat (4) tick();
        check_both("bp_drain_busy", ifa.busy, ifb.busy, 1'b0);

        // watchdog fires after 4 cycles in BUSY
        auto_done = 1'b0;
        x_req = 1'b1;
        wait_token("wd", t);
        x_req = 1'b0;
        tick();
        check_both("wd_accept_busy", ifa.busy, ifb.busy, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_both($sformatf("wd_busy[%0d]", i), ifa.busy, ifb.busy, 1'b1);
            check_both($sformatf("wd_err[%0d]", i),  ifa.err,  ifb.err,  1'b0);
        end
        tick();
        check_both("wd_fire_busy", ifa.busy, ifb.busy, 1'b0);
        check_both("wd_fire_err",  ifa.err,  ifb.err,  1'b1);

        // err is sticky across normal traffic
        auto_done = 1'b1;
        x_req = 1'b1;
        wait_token("sticky", t);
        x_req = 1'b0;
        repeat (4) tick();
        check_both("sticky_err",  ifa.err,  ifb.err,  1'b1);
        check_both("sticky_busy", ifa.busy, ifb.busy, 1'b0);

        // asynchronous reset in the middle of BUSY
        auto_done = 1'b0;
        x_req = 1'b1;
        wait_token("arst", t);
        x_req = 1'b0;
        tick();
        check_both("arst_pre_busy", ifa.busy, ifb.busy, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_both("arst_sel_valid", ifa.sel_valid, ifb.sel_valid, 1'b0);
        check_both("arst_busy",      ifa.busy,      ifb.busy,      1'b0);
        check_both("arst_err",       ifa.err,       ifb.err,       1'b0);
        x_req = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        check_both("arst_token_valid", ifa.sel_valid, ifb.sel_valid, 1'b1);
        check_both("arst_token_data",  ifa.sel_data,  ifb.sel_data,  1'b0);

        // done lands on the 4th BUSY cycle: completion, no error
        x_req = 1'b0;
        tick();
        repeat (3) tick();
        check_both("wd4_busy", ifa.busy, ifb.busy, 1'b1);
        done = 1'b1;
        tick();
        check_both("wd4_idle", ifa.busy, ifb.busy, 1'b0);
        check_both("wd4_err",  ifa.err,  ifb.err,  1'b0);

        // done while IDLE is ignored
        done = 1'b1;
        tick();
        check_both("stray_done_busy",  ifa.busy,      ifb.busy,      1'b0);
        check_both("stray_done_valid", ifa.sel_valid, ifb.sel_valid, 1'b0);
        check_both("stray_done_err",   ifa.err,       ifb.err,       1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
